key_stream_loader: RTL and testbench

//  - Sequential key-delivery front end for our key-locked combinational benchmarks.
//  - Receives the unlock key as a serial bit stream from the key store / scan port.
//  - Assembles it in a shadow register.
//  - Commits it atomically to a parallel bus that drives the keyIn_* inputs of a locked netlist.
//  - The locked netlist never sees a partially loaded key.

---
 rtl/key_loader_pkg.sv | 14 +
 rtl/key_stream_loader.sv | 175 +++++++++++++++++
 tb/tb_key_stream_loader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/key_loader_pkg.sv
// Shared definitions for the serial key loader: default key width and the
// FSM state encoding (fixed here so benches can probe the state register).
package key_loader_pkg;

   localparam int KEY_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      CHECK  = 2'd2,
      COMMIT = 2'd3
   } kl_state_t;

endpackage

// File: rtl/key_stream_loader.sv
// key_stream_loader: assembles a serially delivered unlock key (LSB first)
// in a shadow register and commits it atomically to key_out, so the locked
// netlist never sees a partial key.
// Optional feature macro: KEY_PARITY_EN -- adds one trailing even-parity beat
// that is verified before commit; a failing key raises sticky err instead.
// With parity enabled, a passing CHECK cycle performs the commit itself so
// the key still appears two cycles after the final (parity) beat.
module key_stream_loader
   import key_loader_pkg::*;
#(
   parameter int KEY_W = KEY_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             ser_valid,
   input  logic             ser_data,
   output logic             ser_ready,
   output logic [KEY_W-1:0] key_out,
   output logic             key_valid,
   output logic             busy,
   output logic             err
);

   localparam int               CNT_W        = $clog2(KEY_W + 1);
   localparam logic [CNT_W-1:0] LAST_KEY_BIT = CNT_W'(KEY_W - 1);
`ifdef KEY_PARITY_EN
   localparam logic [CNT_W-1:0] PARITY_SLOT  = CNT_W'(KEY_W);
`endif

   kl_state_t        state_reg, state_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [KEY_W-1:0] shadow_reg, shadow_next;
   logic [KEY_W-1:0] key_out_reg, key_out_next;
   logic             key_valid_reg, key_valid_next;
   logic             busy_reg, busy_next;
   logic             ser_ready_reg, ser_ready_next;
   logic             clear_load;
   logic             beat;
`ifdef KEY_PARITY_EN
   logic             parity_reg, parity_next;
   logic             err_reg, err_next;
`endif

   // A bit is accepted only when offered while ready; a concurrent start
   // aborts the load, so that bit is discarded.
   assign beat = ser_valid && ser_ready_reg && !start;

   // Shadow bit gi captures the stream bit whose position equals the counter.
   for (genvar gi = 0; gi < KEY_W; gi++) begin : g_shadow
      assign shadow_next[gi] = clear_load ? 1'b0 :
                               (beat && (count_reg == CNT_W'(gi))) ? ser_data :
                               shadow_reg[gi];
   end

   // Next-state and next-output logic for the load sequencer.
   always_comb begin
      state_next     = state_reg;
      count_next     = count_reg;
      key_out_next   = key_out_reg;
      key_valid_next = key_valid_reg;
      clear_load     = 1'b0;
`ifdef KEY_PARITY_EN
      err_next       = err_reg;
      parity_next    = parity_reg;
`endif

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next     = SHIFT;
               clear_load     = 1'b1;
               key_valid_next = 1'b0;
`ifdef KEY_PARITY_EN
               err_next       = 1'b0;
`endif
            end
         end
         SHIFT: begin
            if (start) begin
               clear_load = 1'b1;
`ifdef KEY_PARITY_EN
               err_next   = 1'b0;
`endif
            end else if (beat) begin
               count_next = count_reg + CNT_W'(1);
`ifdef KEY_PARITY_EN
               parity_next = parity_reg ^ ser_data;
               if (count_reg == PARITY_SLOT) begin
                  state_next = CHECK;
               end
`else
               if (count_reg == LAST_KEY_BIT) begin
                  state_next = COMMIT;
               end
`endif
            end
         end
         CHECK: begin
`ifdef KEY_PARITY_EN
            if (start) begin
               state_next = SHIFT;
               clear_load = 1'b1;
               err_next   = 1'b0;
            end else if (parity_reg == 1'b0) begin
               key_out_next   = shadow_reg;
               key_valid_next = 1'b1;
               state_next     = IDLE;
            end else begin
               err_next   = 1'b1;
               state_next = IDLE;
            end
`else
            state_next = IDLE;
`endif
         end
         COMMIT: begin
            key_out_next   = shadow_reg;
            key_valid_next = 1'b1;
            state_next     = IDLE;
         end
      endcase

      if (clear_load) begin
         count_next = '0;
`ifdef KEY_PARITY_EN
         parity_next = 1'b0;
`endif
      end

      ser_ready_next = (state_next == SHIFT);
      busy_next      = (state_next == SHIFT) || (state_next == CHECK) ||
                       (state_next == COMMIT);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         count_reg     <= '0;
         shadow_reg    <= '0;
         key_out_reg   <= '0;
         key_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
         ser_ready_reg <= 1'b0;
`ifdef KEY_PARITY_EN
         parity_reg    <= 1'b0;
         err_reg       <= 1'b0;
`endif
      end else begin
         state_reg     <= state_next;
         count_reg     <= count_next;
         shadow_reg    <= shadow_next;
         key_out_reg   <= key_out_next;
         key_valid_reg <= key_valid_next;
         busy_reg      <= busy_next;
         ser_ready_reg <= ser_ready_next;
`ifdef KEY_PARITY_EN
         parity_reg    <= parity_next;
         err_reg       <= err_next;
`endif
      end
   end

   assign ser_ready = ser_ready_reg;
   assign key_out   = key_out_reg;
   assign key_valid = key_valid_reg;
   assign busy      = busy_reg;
`ifdef KEY_PARITY_EN
   assign err       = err_reg;
`else
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_key_stream_loader.sv
// Self-checking bench for key_stream_loader: directed reset/load/stall/abort
// scenarios followed by randomized loads, compared against a reference model
// that rebuilds each key from the transmitted bit list.
// Honours KEY_PARITY_EN when defined for the build.
module tb_key_stream_loader;
   import key_loader_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        ser_valid;
   logic        ser_data;
   logic        ser_ready;
   logic [15:0] key_out;
   logic        key_valid;
   logic        busy;
   logic        err;

   int errors = 0;
   int checks = 0;

   // reference model state: what the committed outputs should be
   logic [15:0] exp_key   = 16'h0000;
   logic        exp_valid = 1'b0;
   logic        exp_err   = 1'b0;

   key_stream_loader #(.KEY_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .ser_valid (ser_valid),
      .ser_data  (ser_data),
      .ser_ready (ser_ready),
      .key_out   (key_out),
      .key_valid (key_valid),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Sends one key (plus parity beat when enabled), optionally stalling after
   // bit stall_at for stall_len cycles, and checks the commit two cycles later.
   task automatic load(input logic [15:0] key, input int stall_at, input int stall_len,
                       input bit par, input bit start_in_commit);
      bit     bits[$];
      logic [15:0] assembled;
      bit     ok;
      start = 1'b1; ser_valid = 1'b0;
      tick();
      start = 1'b0;
      exp_valid = 1'b0; exp_err = 1'b0;
      check("ready_in_shift", ser_ready, 1);
      check("busy_in_shift", busy, 1);
      check("valid_cleared", key_valid, 0);
      for (int i = 0; i < 16; i++) bits.push_back(key[i]);
      for (int i = 0; i < 16; i++) begin
         ser_valid = 1'b1; ser_data = bits[i];
         tick();
         if (i == stall_at) begin
            ser_valid = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               ser_data = 1'($urandom);
               tick();
               check("stall_ready", ser_ready, 1);
               check("stall_count", 32'(dut.count_reg), 32'(i + 1));
            end
         end
      end
`ifdef KEY_PARITY_EN
      ser_valid = 1'b1; ser_data = par;
      tick();
`endif
      ser_valid = 1'b0;
`ifndef KEY_PARITY_EN
      start = start_in_commit;
`endif
      check("valid_before_commit", key_valid, 0);
      check("key_held_before_commit", key_out, exp_key);
      tick();
      start = 1'b0;
      assembled = '0;
      for (int i = 0; i < 16; i++) assembled = assembled + (16'(bits[i]) << i);
      ok = 1'b1;
`ifdef KEY_PARITY_EN
      ok = ((assembled[0] + assembled[1] + assembled[2] + assembled[3] + assembled[4] +
             assembled[5] + assembled[6] + assembled[7] + assembled[8] + assembled[9] +
             assembled[10] + assembled[11] + assembled[12] + assembled[13] + assembled[14] +
             assembled[15] + 32'(par)) % 2) == 0;
`endif
      if (ok) begin
         exp_key = assembled; exp_valid = 1'b1; exp_err = 1'b0;
      end else begin
         exp_valid = 1'b0; exp_err = 1'b1;
      end
      check("key_out", key_out, exp_key);
      check("key_valid", key_valid, exp_valid);
      check("err", err, exp_err);
      check("busy_after", busy, 0);
      check("ready_after", ser_ready, 0);
      if (start_in_commit) begin
         tick();
         check("commit_start_state", 32'(dut.state_reg), 32'(IDLE));
         check("commit_start_busy", busy, 0);
         check("commit_start_valid", key_valid, exp_valid);
      end
      $display("load key=%h par=%0d stall_at=%0d len=%0d -> key_out=%h valid=%0d err=%0d",
               key, par, stall_at, stall_len, key_out, key_valid, err);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; ser_valid = 1'b0; ser_data = 1'b0;
      tick(); tick();
      check("rst_key", key_out, 16'h0000);
      check("rst_valid", key_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", ser_ready, 0);
      check("rst_err", err, 0);
      rst_n = 1'b1;

      // ser_valid in IDLE is ignored
      ser_valid = 1'b1; ser_data = 1'b1;
      tick(); tick();
      check("idle_ready", ser_ready, 0);
      check("idle_key", key_out, 16'h0000);
      ser_valid = 1'b0;

      // plain load, stalled load
      load(16'hA5C3, -1, 0, 1'b0, 1'b0);
      load(16'hA5C3, 7, 5, 1'b0, 1'b0);

      // abort with garbage, then reload
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         ser_valid = 1'b1; ser_data = 1'($urandom);
         tick();
         check("abort_key_held", key_out, 16'hA5C3);
      end
      load(16'h1234, -1, 0, 1'b1, 1'b0);

      // reset in the middle of a load
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         ser_valid = 1'b1; ser_data = 1'b1; tick();
      end
      ser_valid = 1'b0; rst_n = 1'b0;
      tick();
      exp_key = 16'h0000; exp_valid = 1'b0; exp_err = 1'b0;
      check("midrst_key", key_out, 16'h0000);
      check("midrst_valid", key_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_ready", ser_ready, 0);
      check("midrst_err", err, 0);
      rst_n = 1'b1;
      load(16'hFFFF, -1, 0, 1'b0, 1'b0);

      // start asserted during the commit cycle is ignored
      load(16'h5A5A, 3, 2, 1'b0, 1'b1);

`ifdef KEY_PARITY_EN
      load(16'hA5C3, -1, 0, 1'b0, 1'b0);
      load(16'hA5C3, -1, 0, 1'b1, 1'b0);
      check("parity_fail_key", key_out, 16'hA5C3);
`endif

      // randomized loads
      for (int n = 0; n < 12; n++) begin
         load(16'($urandom), int'($urandom_range(0, 14)), int'($urandom_range(0, 3)),
              1'($urandom), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
